fetch_stage: RTL and testbench

//  IF stage of the mips32 pipeline: owns the PC, drives the instruction-memory

---
 rtl/fetch_if.sv | 34 +++
 rtl/fetch_stage.sv | 112 +++++++++++
 tb/tb_fetch_stage.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/fetch_if.sv
// Signal bundle between the IF stage (master) and its surroundings: hazard
// controls, redirect targets, instruction-memory handshake and the IF/ID outputs.
interface fetch_if;
    logic        pcWrite;
    logic        jumpStall;
    logic        ifIdFlush;
    logic        branchTaken;
    logic [31:0] branchTarget;
    logic        jumpTaken;
    logic [31:0] jumpTarget;
    logic [31:0] imemAddr;
    logic        imemReq;
    logic [31:0] imemData;
    logic        imemReady;
    logic [31:0] instrOut;
    logic [31:0] pcOut;
    logic [31:0] pcPlus4Out;
    logic        validOut;
    logic [1:0]  dbgState;

    // Handshake: a fetch completes on a rising edge where imemReq=1 and
    // imemReady=1; while imemReady=0 the stage keeps imemReq and imemAddr stable.
    modport master (
        input  pcWrite, jumpStall, ifIdFlush, branchTaken, branchTarget,
               jumpTaken, jumpTarget, imemData, imemReady,
        output imemAddr, imemReq, instrOut, pcOut, pcPlus4Out, validOut, dbgState
    );

    modport slave (
        output pcWrite, jumpStall, ifIdFlush, branchTaken, branchTarget,
               jumpTaken, jumpTarget, imemData, imemReady,
        input  imemAddr, imemReq, instrOut, pcOut, pcPlus4Out, validOut, dbgState
    );
endinterface

// File: rtl/fetch_stage.sv
// MIPS32 IF stage: owns the PC, runs the instruction-memory request handshake
// and the IF/ID pipeline register, honouring stalls, flushes and redirects.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic   clock,
    input  logic   reset,
    fetch_if.master bus
);
    typedef enum logic [1:0] {
        S_BOOT  = 2'd0,
        S_FETCH = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    state_t      r_state, w_state_nxt;
    logic [31:0] r_pc, w_pc_nxt;
    logic        r_pend_valid, w_pend_valid_nxt;
    logic [31:0] r_pend_target, w_pend_target_nxt;
    logic [31:0] r_instr, r_pc_out, r_pc_plus4;
    logic        r_valid;

    logic        w_req;
    logic        w_done;
    logic        w_redirect;
    logic [31:0] w_target;
    logic [31:0] w_pc_plus4;

    assign w_req      = (r_state != S_BOOT);
    assign w_done     = w_req && bus.imemReady;
    assign w_redirect = bus.branchTaken || bus.jumpTaken;
    assign w_target   = bus.branchTaken ? bus.branchTarget : bus.jumpTarget;
    assign w_pc_plus4 = r_pc + 32'd4;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state       <= S_BOOT;
            r_pc          <= RESET_PC;
            r_pend_valid  <= 1'b0;
            r_pend_target <= 32'h0;
        end else begin
            r_state       <= w_state_nxt;
            r_pc          <= w_pc_nxt;
            r_pend_valid  <= w_pend_valid_nxt;
            r_pend_target <= w_pend_target_nxt;
        end
    end

    always_comb begin
        w_state_nxt       = r_state;
        w_pc_nxt          = r_pc;
        w_pend_valid_nxt  = r_pend_valid;
        w_pend_target_nxt = r_pend_target;
        case (r_state)
            S_BOOT:  w_state_nxt = S_FETCH;
            default: w_state_nxt = bus.imemReady ? S_FETCH : S_WAIT;
        endcase
        // An in-flight WAIT request must keep its address, so the target is parked.
        if (w_redirect && (r_state == S_WAIT) && !w_done) begin
            w_pend_valid_nxt  = 1'b1;
            w_pend_target_nxt = w_target;
        end else if (w_redirect) begin
            w_pc_nxt         = w_target;
            w_pend_valid_nxt = 1'b0;
        end else if (r_pend_valid) begin
            if (w_done) begin
                w_pc_nxt         = r_pend_target;
                w_pend_valid_nxt = 1'b0;
            end
        end else if (w_done && bus.pcWrite && !bus.jumpStall) begin
            w_pc_nxt = w_pc_plus4;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_instr    <= NOP_INSTR;
            r_pc_out   <= 32'h0;
            r_pc_plus4 <= 32'h0;
            r_valid    <= 1'b0;
        end else if (bus.ifIdFlush || w_redirect) begin
            r_instr    <= NOP_INSTR;
            r_pc_out   <= 32'h0;
            r_pc_plus4 <= 32'h0;
            r_valid    <= 1'b0;
        end else if (!bus.pcWrite) begin
            r_instr    <= r_instr;
            r_pc_out   <= r_pc_out;
            r_pc_plus4 <= r_pc_plus4;
            r_valid    <= r_valid;
        end else if (w_done && !bus.jumpStall && !r_pend_valid) begin
            r_instr    <= bus.imemData;
            r_pc_out   <= r_pc;
            r_pc_plus4 <= w_pc_plus4;
            r_valid    <= 1'b1;
        end else begin
            r_instr    <= NOP_INSTR;
            r_pc_out   <= 32'h0;
            r_pc_plus4 <= 32'h0;
            r_valid    <= 1'b0;
        end
    end

    assign bus.imemAddr   = r_pc;
    assign bus.imemReq    = w_req;
    assign bus.instrOut   = r_instr;
    assign bus.pcOut      = r_pc_out;
    assign bus.pcPlus4Out = r_pc_plus4;
    assign bus.validOut   = r_valid;
    assign bus.dbgState   = r_state;
endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed pipeline scenarios followed by random traffic,
// all checked cycle by cycle against a transaction-level model of the IF stage.
module tb_fetch_stage;
  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  fetch_if ifa();
  fetch_if ifb();

  fetch_stage #(.RESET_PC(32'h0000_0000), .NOP_INSTR(32'h0000_0000)) u_dut (
    .clock(clock), .reset(reset), .bus(ifa));
  fetch_stage #(.RESET_PC(32'hFFFF_FFFC), .NOP_INSTR(32'h0000_0000)) u_dut_hi (
    .clock(clock), .reset(reset), .bus(ifb));

  assign ifb.pcWrite      = ifa.pcWrite;
  assign ifb.jumpStall    = ifa.jumpStall;
  assign ifb.ifIdFlush    = ifa.ifIdFlush;
  assign ifb.branchTaken  = ifa.branchTaken;
  assign ifb.branchTarget = ifa.branchTarget;
  assign ifb.jumpTaken    = ifa.jumpTaken;
  assign ifb.jumpTarget   = ifa.jumpTarget;
  assign ifb.imemData     = ifa.imemData;
  assign ifb.imemReady    = ifa.imemReady;

  int tests = 0;
  int fails = 0;
  logic [31:0] salt = 32'h0;

  // reference model: PC, whether the stage is running, an outstanding unanswered
  // request, a parked redirect, and the IF/ID contents
  logic [31:0] m_pc;
  logic        m_running;
  logic        m_outstanding;
  logic [31:0] pend_q[$];
  logic [31:0] m_instr, m_pco, m_pc4;
  logic        m_valid;
  logic [96:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a >> 2) ^ salt;
  endfunction

  task automatic model_reset(input logic [31:0] rpc);
    m_pc = rpc; m_running = 1'b0; m_outstanding = 1'b0;
    pend_q.delete(); exp_q.delete();
    m_instr = 32'h0; m_pco = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
  endtask

  task automatic bubble();
    m_instr = 32'h0; m_pco = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
  endtask

  task automatic model_step(input logic pw, js, fl, bt, input logic [31:0] btg,
                            input logic jt, input logic [31:0] jtg, input logic rdy);
    logic done, redir, discard;
    logic [31:0] tgt;
    done    = m_running && rdy;
    redir   = bt || jt;
    tgt     = bt ? btg : jtg;
    discard = redir || (pend_q.size() != 0);
    if (fl || redir) bubble();
    else if (!pw) begin end
    else if (js) bubble();
    else if (done && !discard) begin
      m_instr = mem_word(m_pc); m_pco = m_pc; m_pc4 = m_pc + 32'd4; m_valid = 1'b1;
    end else bubble();
    if (redir && m_outstanding && !done) begin
      pend_q.delete(); pend_q.push_back(tgt);
    end else if (redir) begin
      m_pc = tgt; pend_q.delete();
    end else if (pend_q.size() != 0) begin
      if (done) m_pc = pend_q.pop_front();
    end else if (done && pw && !js) m_pc = m_pc + 32'd4;
    m_outstanding = m_running && !rdy;
    m_running = 1'b1;
    exp_q.push_back({m_instr, m_pco, m_pc4, m_valid});
  endtask

  task automatic cycle(input logic pw, js, fl, bt, input logic [31:0] btg,
                       input logic jt, input logic [31:0] jtg, input logic rdy);
    logic [96:0] e;
    @(negedge clock);
    ifa.pcWrite = pw; ifa.jumpStall = js; ifa.ifIdFlush = fl;
    ifa.branchTaken = bt; ifa.branchTarget = btg;
    ifa.jumpTaken = jt; ifa.jumpTarget = jtg;
    ifa.imemReady = rdy; ifa.imemData = mem_word(m_pc);
    #1;
    chk("imemAddr", ifa.imemAddr, m_pc);
    chk("imemReq", {31'b0, ifa.imemReq}, {31'b0, m_running});
    model_step(pw, js, fl, bt, btg, jt, jtg, rdy);
    @(posedge clock);
    #1;
    e = exp_q.pop_front();
    chk("instrOut", ifa.instrOut, e[96:65]);
    chk("pcOut", ifa.pcOut, e[64:33]);
    chk("pcPlus4Out", ifa.pcPlus4Out, e[32:1]);
    chk("validOut", {31'b0, ifa.validOut}, {31'b0, e[0]});
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle(1, 0, 0, 0, 32'h0, 0, 32'h0, 1);
  endtask

  task automatic do_reset();
    #3 reset = 1'b0;
    #1;
    chk("rst_imemAddr", ifa.imemAddr, 32'h0000_0000);
    chk("rst_imemReq", {31'b0, ifa.imemReq}, 32'h0);
    chk("rst_instrOut", ifa.instrOut, 32'h0);
    chk("rst_pcOut", ifa.pcOut, 32'h0);
    chk("rst_pcPlus4Out", ifa.pcPlus4Out, 32'h0);
    chk("rst_validOut", {31'b0, ifa.validOut}, 32'h0);
    chk("rst_hi_imemAddr", ifb.imemAddr, 32'hFFFF_FFFC);
    chk("rst_hi_imemReq", {31'b0, ifb.imemReq}, 32'h0);
    chk("rst_hi_validOut", {31'b0, ifb.validOut}, 32'h0);
    chk("rst_hi_pcOut", ifb.pcOut, 32'h0);
    model_reset(32'h0);
    @(posedge clock);
    #2 reset = 1'b1;
  endtask

  initial begin
    ifa.pcWrite = 1; ifa.jumpStall = 0; ifa.ifIdFlush = 0;
    ifa.branchTaken = 0; ifa.branchTarget = 0; ifa.jumpTaken = 0; ifa.jumpTarget = 0;
    ifa.imemReady = 0; ifa.imemData = 0;
    model_reset(32'h0);
    #12;
    do_reset();

    // T1 streaming fetch, one instruction per cycle
    cycle(1, 0, 0, 0, 32'h0, 0, 32'h0, 1);
    run(2);
    // T2 load-use stall at PC=8
    cycle(0, 0, 0, 0, 32'h0, 0, 32'h0, 1);
    cycle(0, 0, 0, 0, 32'h0, 0, 32'h0, 1);
    run(3);
    // T3 jump stall bubbles then jump
    cycle(1, 1, 0, 0, 32'h0, 0, 32'h0, 1);
    cycle(1, 1, 0, 0, 32'h0, 0, 32'h0, 1);
    cycle(1, 0, 0, 0, 32'h0, 1, 32'h40, 1);
    run(2);
    // T4 branch beats jump
    cycle(1, 0, 0, 1, 32'h100, 1, 32'h200, 1);
    run(2);
    cycle(1, 0, 1, 0, 32'h0, 0, 32'h0, 1);
    run(1);
    // T5 branch parked during a memory wait at 0x10
    cycle(1, 0, 0, 0, 32'h0, 1, 32'h10, 1);
    cycle(1, 0, 0, 0, 32'h0, 0, 32'h0, 0);
    cycle(1, 0, 0, 1, 32'h80, 0, 32'h0, 0);
    cycle(1, 0, 0, 0, 32'h0, 0, 32'h0, 0);
    cycle(1, 0, 0, 0, 32'h0, 0, 32'h0, 1);
    run(2);
    // T6 PC wrap and reset mid-WAIT
    cycle(1, 0, 0, 0, 32'h0, 1, 32'hFFFF_FFFC, 1);
    run(3);
    do_reset();
    cycle(1, 0, 0, 0, 32'h0, 0, 32'h0, 1);
    cycle(1, 0, 0, 0, 32'h0, 0, 32'h0, 1);
    chk("hi_pcOut", ifb.pcOut, 32'hFFFF_FFFC);
    chk("hi_pcPlus4Out", ifb.pcPlus4Out, 32'h0000_0000);
    chk("hi_imemAddr_wrap", ifb.imemAddr, 32'h0000_0000);
    chk("hi_validOut", {31'b0, ifb.validOut}, 32'h1);
    cycle(1, 0, 0, 0, 32'h0, 0, 32'h0, 0);
    cycle(1, 0, 0, 0, 32'h0, 0, 32'h0, 0);
    do_reset();

    // random traffic
    salt = $urandom;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(199) == 0) do_reset();
      cycle($urandom_range(99) < 85, $urandom_range(99) < 10, $urandom_range(99) < 5,
            $urandom_range(99) < 6, {$urandom_range(32'h3FFF_FFFF), 2'b00},
            $urandom_range(99) < 6, {$urandom_range(32'h3FFF_FFFF), 2'b00},
            $urandom_range(99) < 70);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
